neurram_spi_scheduler: RTL and testbench



---
 rtl/neurram_spi_scheduler.sv | 165 ++++++++++++++++
 tb/tb_neurram_spi_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/neurram_spi_scheduler.sv
// neurram_spi_scheduler
//   Arbitrates SPI jobs from two requesters (host wire path and on-chip
//   inference sequencer), launches each job on the shared SPI controller,
//   supervises its busy/idle handshake with bounded waits and reports the
//   completion. Only one job is ever in flight.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake ([0] host, [1] sequencer)
//   req0_desc/req1_desc job descriptors {tag, extra, pipe_out, pipe_in, mult, cfg}
//   spi_trigger         one-cycle launch pulse to the SPI controller
//   spi_config .. extra_shift_cycles  job fields held from acceptance
//   spi_idle            SPI controller idle flag
//   timeout_limit       WAIT_IDLE cycle limit, 0 disables the timeout
//   done_valid/src/tag/error  completion report
//   busy                high whenever a job is in progress
//   job_count           completed jobs (including errored), wraps at 2^16
module neurram_spi_scheduler #(
  parameter int TIMEOUT_W = 24,
  parameter int BUSY_WAIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [21:0]          req0_desc,
  input  logic [21:0]          req1_desc,
  output logic                 spi_trigger,
  output logic [1:0]           spi_config,
  output logic [3:0]           shift_multiplier,
  output logic [3:0]           pipe_in_steps,
  output logic [3:0]           pipe_out_steps,
  output logic [3:0]           extra_shift_cycles,
  input  logic                 spi_idle,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic                 done_valid,
  output logic                 done_src,
  output logic [3:0]           done_tag,
  output logic                 done_error,
  output logic                 busy,
  output logic [15:0]          job_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_WAIT_IDLE,
    S_DONE
  } state_t;

  // Last WAIT_BUSY count value; reaching it means BUSY_WAIT cycles elapsed.
  localparam logic [TIMEOUT_W-1:0] BUSY_LAST = TIMEOUT_W'(BUSY_WAIT - 1);

  state_t               state, state_nx;
  logic [TIMEOUT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic                 rr_ptr;    // requester favoured when both are valid
  logic                 src;       // requester of the job in flight
  logic [3:0]           tag;       // tag of the job in flight
  logic                 err_nx;
  logic                 accept;
  logic                 grant_idx;
  logic [21:0]          desc_sel;

  // Count up, sticking at all-ones so an unlimited wait never wraps.
  function automatic logic [TIMEOUT_W-1:0] sat_inc(input logic [TIMEOUT_W-1:0] v);
    return (&v) ? v : v + TIMEOUT_W'(1);
  endfunction

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    err_nx    = 1'b0;
    accept    = 1'b0;
    grant_idx = 1'b0;
    req_ready = 2'b00;
    cnt_inc   = sat_inc(cnt);
    case (state)
      S_IDLE: begin
        // No grant while the controller is not idle (covers post-reset).
        if (!rst && spi_idle && (|req_valid)) begin
          accept    = 1'b1;
          grant_idx = (&req_valid) ? rr_ptr : req_valid[1];
          req_ready = grant_idx ? 2'b10 : 2'b01;
          state_nx  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_nx = S_WAIT_BUSY;
        cnt_nx   = '0;
      end
      S_WAIT_BUSY: begin
        if (!spi_idle) begin
          state_nx = S_WAIT_IDLE;
          cnt_nx   = '0;
        end else if (cnt == BUSY_LAST) begin
          state_nx = S_DONE;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      S_WAIT_IDLE: begin
        if (spi_idle) begin
          state_nx = S_DONE;
        end else begin
          cnt_nx = cnt_inc;
          if ((timeout_limit != '0) && (cnt_inc == timeout_limit)) begin
            state_nx = S_DONE;
            err_nx   = 1'b1;
          end
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    desc_sel = grant_idx ? req1_desc : req0_desc;
  end

  // Registered state and outputs; every output is cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      cnt                <= '0;
      rr_ptr             <= 1'b0;
      src                <= 1'b0;
      tag                <= '0;
      spi_trigger        <= 1'b0;
      spi_config         <= '0;
      shift_multiplier   <= '0;
      pipe_in_steps      <= '0;
      pipe_out_steps     <= '0;
      extra_shift_cycles <= '0;
      done_valid         <= 1'b0;
      done_src           <= 1'b0;
      done_tag           <= '0;
      done_error         <= 1'b0;
      busy               <= 1'b0;
      job_count          <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      spi_trigger <= accept;
      busy        <= (state_nx != S_IDLE);
      done_valid  <= (state_nx == S_DONE);
      if (accept) begin
        rr_ptr             <= ~grant_idx;
        src                <= grant_idx;
        tag                <= desc_sel[21:18];
        spi_config         <= desc_sel[1:0];
        shift_multiplier   <= desc_sel[5:2];
        pipe_in_steps      <= desc_sel[9:6];
        pipe_out_steps     <= desc_sel[13:10];
        extra_shift_cycles <= desc_sel[17:14];
      end
      if (state_nx == S_DONE) begin
        done_src   <= src;
        done_tag   <= tag;
        done_error <= err_nx;
        job_count  <= job_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_neurram_spi_scheduler.sv
// Testbench for neurram_spi_scheduler: table of jobs with hand-computed
// grants, tags, error flags and completion latencies, followed by
// hand-written sequences for the disabled timeout, mid-job reset and the
// post-reset idle window. The SPI controller is modelled inline.
module tb_neurram_spi_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [21:0] req0_desc;
  logic [21:0] req1_desc;
  logic        spi_trigger;
  logic [1:0]  spi_config;
  logic [3:0]  shift_multiplier;
  logic [3:0]  pipe_in_steps;
  logic [3:0]  pipe_out_steps;
  logic [3:0]  extra_shift_cycles;
  logic        spi_idle;
  logic [23:0] timeout_limit;
  logic        done_valid;
  logic        done_src;
  logic [3:0]  done_tag;
  logic        done_error;
  logic        busy;
  logic [15:0] job_count;

  neurram_spi_scheduler #(.TIMEOUT_W(24), .BUSY_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_desc(req0_desc), .req1_desc(req1_desc),
    .spi_trigger(spi_trigger), .spi_config(spi_config),
    .shift_multiplier(shift_multiplier), .pipe_in_steps(pipe_in_steps),
    .pipe_out_steps(pipe_out_steps), .extra_shift_cycles(extra_shift_cycles),
    .spi_idle(spi_idle), .timeout_limit(timeout_limit),
    .done_valid(done_valid), .done_src(done_src), .done_tag(done_tag),
    .done_error(done_error), .busy(busy), .job_count(job_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: idle falls at k=2 and rises at k=2+blen; 1: stays idle;
  // 2: falls at k=2 and never rises. lat = negedges from trigger to done.
  typedef struct {
    logic [1:0]  rv;
    logic [21:0] d0;
    logic [21:0] d1;
    int          mode;
    logic [23:0] limit;
    int          blen;
    int          grant;
    logic [3:0]  tag;
    logic        err;
    int          lat;
  } vec_t;

  vec_t tbl[9];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [21:0] mk_desc(input logic [3:0] t, input logic [3:0] ex,
                                          input logic [3:0] po, input logic [3:0] pi,
                                          input logic [3:0] mu, input logic [1:0] cf);
    return {t, ex, po, pi, mu, cf};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outs();
    return {19'd0, req_ready, spi_trigger, spi_config, shift_multiplier, pipe_in_steps,
            pipe_out_steps, extra_shift_cycles, done_valid, done_src, done_tag,
            done_error, busy, job_count};
  endfunction

  // Entered at a negedge with the scheduler in IDLE; leaves at the negedge
  // after the done pulse, again in IDLE.
  task automatic run_job(input vec_t v, input int exp_jc);
    logic [21:0] ed;
    int          trig_cnt;
    int          lat;
    ed = (v.grant == 1) ? v.d1 : v.d0;
    req_valid     = v.rv;
    req0_desc     = v.d0;
    req1_desc     = v.d1;
    timeout_limit = v.limit;
    spi_idle      = 1'b1;
    #1;
    check("req_ready", req_ready, (v.grant == 1) ? 2'b10 : 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    check("trigger", spi_trigger, 1'b1);
    check("req_ready_inflight", req_ready, 2'b00);
    check("spi_fields", {extra_shift_cycles, pipe_out_steps, pipe_in_steps,
                         shift_multiplier, spi_config}, ed[17:0]);
    trig_cnt = 1;
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (spi_trigger) trig_cnt++;
      if (done_valid) begin
        lat = k;
        break;
      end
      if (v.mode != 1 && k == 2) spi_idle = 1'b0;
      if (v.mode == 0 && k == 2 + v.blen) spi_idle = 1'b1;
    end
    check("done_latency", lat, v.lat);
    check("trigger_count", trig_cnt, 1);
    check("done_src", done_src, v.grant[0]);
    check("done_tag", done_tag, v.tag);
    check("done_error", done_error, v.err);
    check("job_count", job_count, exp_jc);
    check("busy_done", busy, 1'b1);
    spi_idle = 1'b1;
    @(negedge clk);
    check("done_pulse_end", {done_valid, busy}, 2'b00);
    check("done_tag_hold", done_tag, v.tag);
  endtask

  initial begin
    int   bad;
    vec_t v;
    tbl[0] = '{2'b01, mk_desc(4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 2'b11),
               mk_desc(4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00), 0, 24'd0, 40, 0, 4'd5, 1'b0, 43};
    tbl[1] = '{2'b10, mk_desc(4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 2'b01),
               mk_desc(4'd6, 4'd7, 4'd6, 4'd5, 4'd4, 2'b01), 0, 24'd0, 10, 1, 4'd6, 1'b0, 13};
    tbl[2] = '{2'b11, mk_desc(4'd2, 4'd8, 4'd9, 4'd10, 4'd11, 2'b00),
               mk_desc(4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 2'b11), 0, 24'd0, 3, 0, 4'd2, 1'b0, 6};
    tbl[3] = '{2'b11, mk_desc(4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 2'b10),
               mk_desc(4'd12, 4'd15, 4'd14, 4'd13, 4'd12, 2'b10), 0, 24'd0, 1, 1, 4'd12, 1'b0, 4};
    tbl[4] = '{2'b11, mk_desc(4'd7, 4'd2, 4'd5, 4'd8, 4'd1, 2'b01),
               mk_desc(4'd8, 4'd6, 4'd6, 4'd6, 4'd6, 2'b00), 0, 24'd0, 20, 0, 4'd7, 1'b0, 23};
    tbl[5] = '{2'b11, mk_desc(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00),
               mk_desc(4'd13, 4'd9, 4'd7, 4'd5, 4'd3, 2'b11), 0, 24'd0, 2, 1, 4'd13, 1'b0, 5};
    tbl[6] = '{2'b01, mk_desc(4'd10, 4'd3, 4'd1, 4'd4, 4'd1, 2'b10),
               mk_desc(4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00), 1, 24'd0, 0, 0, 4'd10, 1'b1, 9};
    tbl[7] = '{2'b10, mk_desc(4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 2'b00),
               mk_desc(4'd11, 4'd5, 4'd9, 4'd2, 4'd6, 2'b01), 2, 24'd100, 0, 1, 4'd11, 1'b1, 103};
    tbl[8] = '{2'b11, mk_desc(4'd14, 4'd12, 4'd11, 4'd10, 4'd9, 2'b11),
               mk_desc(4'd15, 4'd1, 4'd1, 4'd1, 4'd1, 2'b01), 0, 24'd100, 5, 0, 4'd14, 1'b0, 8};

    rst = 1'b1;
    req_valid = 2'b11;
    req0_desc = '0;
    req1_desc = '0;
    spi_idle = 1'b1;
    timeout_limit = '0;
    @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    spi_idle = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, job_count}, 17'd0);

    for (int i = 0; i < 9; i++) run_job(tbl[i], i + 1);

    // Disabled timeout: job stays in WAIT_IDLE indefinitely.
    req_valid = 2'b01;
    req0_desc = mk_desc(4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 2'b01);
    timeout_limit = '0;
    spi_idle = 1'b1;
    #1;
    check("nolimit_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    check("nolimit_trigger", spi_trigger, 1'b1);
    bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (done_valid || !busy) bad++;
      if (k == 2) spi_idle = 1'b0;
    end
    check("nolimit_no_done", bad, 0);
    check("nolimit_job_count", job_count, 16'd9);

    // Reset in WAIT_IDLE: outputs clear at once, no done pulse.
    req_valid = 2'b11;
    rst = 1'b1;
    #1;
    check("midjob_reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    check("midjob_no_done", {done_valid, busy}, 2'b00);
    rst = 1'b0;

    // Requests already pending while the controller is still not idle.
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (req_ready != 2'b00) bad++;
      @(negedge clk);
    end
    check("no_ready_while_busy_ctrl", bad, 0);
    check("post_reset_not_busy", busy, 1'b0);

    v = '{2'b11, mk_desc(4'd9, 4'd2, 4'd4, 4'd6, 4'd8, 2'b10),
          mk_desc(4'd4, 4'd1, 4'd1, 4'd1, 4'd1, 2'b01), 0, 24'd0, 4, 0, 4'd9, 1'b0, 7};
    run_job(v, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
